// File: rtl/keypad_bcd_scanner_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
// Shared types and helpers for the 4x4 keypad scanner:
//   - scan_state_t : scanner FSM states (SCAN, DEBOUNCE, HELD)
//   - key_code_t   : 4-bit key code (BCD digits 0-9, operation codes A-F)
//   - KEY_*        : named key code constants
//   - key_map      : (row, col) -> key code
//   - single_low   : true when exactly one active-low column bit is low
//   - low_index    : index of the single low column bit
// ---------------------------------------------------------------------------
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } scan_state_t;

  typedef logic [3:0] key_code_t;

  localparam key_code_t KEY_0    = 4'h0;
  localparam key_code_t KEY_1    = 4'h1;
  localparam key_code_t KEY_2    = 4'h2;
  localparam key_code_t KEY_3    = 4'h3;
  localparam key_code_t KEY_4    = 4'h4;
  localparam key_code_t KEY_5    = 4'h5;
  localparam key_code_t KEY_6    = 4'h6;
  localparam key_code_t KEY_7    = 4'h7;
  localparam key_code_t KEY_8    = 4'h8;
  localparam key_code_t KEY_9    = 4'h9;
  localparam key_code_t KEY_A    = 4'hA;
  localparam key_code_t KEY_B    = 4'hB;
  localparam key_code_t KEY_C    = 4'hC;
  localparam key_code_t KEY_D    = 4'hD;
  localparam key_code_t KEY_STAR = 4'hE;
  localparam key_code_t KEY_HASH = 4'hF;

  // Physical keypad layout: row index selects the driven row, col index the
  // column that reads low.
  function automatic key_code_t key_map(input logic [1:0] row, input logic [1:0] col);
    key_code_t code;
    case ({row, col})
      4'b00_00: code = KEY_1;
      4'b00_01: code = KEY_2;
      4'b00_10: code = KEY_3;
      4'b00_11: code = KEY_A;
      4'b01_00: code = KEY_4;
      4'b01_01: code = KEY_5;
      4'b01_10: code = KEY_6;
      4'b01_11: code = KEY_B;
      4'b10_00: code = KEY_7;
      4'b10_01: code = KEY_8;
      4'b10_10: code = KEY_9;
      4'b10_11: code = KEY_C;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = KEY_0;
      4'b11_10: code = KEY_HASH;
      4'b11_11: code = KEY_D;
      default:  code = KEY_0;
    endcase
    return code;
  endfunction

  // Two or more low columns in one row is a ghost / multi-press and is
  // deliberately rejected here.
  function automatic logic single_low(input logic [3:0] col);
    logic one;
    case (col)
      4'b1110: one = 1'b1;
      4'b1101: one = 1'b1;
      4'b1011: one = 1'b1;
      4'b0111: one = 1'b1;
      default: one = 1'b0;
    endcase
    return one;
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] col);
    logic [1:0] idx;
    case (col)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_bcd_scanner_if.sv
// ---------------------------------------------------------------------------
// keypad_bcd_scanner_if
// Key hand-over bus between the scanner (master) and the consumer (slave).
//   key_code  : buffered key code, valid while key_valid=1
//   key_valid : buffer holds an unconsumed key
//   key_ack   : consumer takes the key (only meaningful while key_valid=1)
//   overflow  : sticky, a confirmed key was dropped because buffer was full
//   key_held  : confirmed key is still physically pressed
// ---------------------------------------------------------------------------
interface keypad_bcd_scanner_if;
  import keypad_pkg::*;

  key_code_t key_code;
  logic      key_valid;
  logic      key_ack;
  logic      overflow;
  logic      key_held;

  modport master (
    output key_code,
    output key_valid,
    output overflow,
    output key_held,
    input  key_ack
  );

  modport slave (
    input  key_code,
    input  key_valid,
    input  overflow,
    input  key_held,
    output key_ack
  );

endinterface

// File: rtl/keypad_bcd_scanner_sync2.sv
// ---------------------------------------------------------------------------
// sync2
// 4-bit two-flop synchronizer for the asynchronous column inputs.
//   clk : sampling clock
//   rst : synchronous active-high reset, both stages reset to all-ones
//         (idle level of the pulled-up active-low columns)
//   d   : asynchronous input
//   q   : synchronized output
// ---------------------------------------------------------------------------
module sync2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta_r;

  // Two-stage capture of the column lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 4'hF;
      q      <= 4'hF;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/keypad_bcd_scanner.sv
// ---------------------------------------------------------------------------
// keypad_bcd_scanner
// Scans a 4x4 active-low keypad matrix, debounces presses and releases,
// rejects ghost / multi-key patterns and hands confirmed key codes over a
// one-entry valid/ack buffer.
//   clk   : sole clock
//   rst   : synchronous active-high reset
//   row_n : active-low row drive, exactly one bit low
//   col_n : active-low column sense, asynchronous
//   kbus  : key hand-over bus (key_code, key_valid, key_ack, overflow,
//           key_held)
// Parameters:
//   SCAN_DIV       : cycles each row is driven (>= 4)
//   DEBOUNCE_SCANS : consecutive matching samples to confirm press/release
// ---------------------------------------------------------------------------
module keypad_bcd_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [3:0]             row_n,
  input  logic [3:0]             col_n,
  keypad_bcd_scanner_if.master   kbus
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_SCANS - 1);

  logic [3:0]       col_s;

  scan_state_t      state_r;
  logic [CNT_W-1:0] dwell_r;
  logic [1:0]       row_idx_r;
  logic [3:0]       lat_col_r;
  logic [1:0]       lat_col_idx_r;
  logic [DB_W-1:0]  match_cnt_r;
  logic [DB_W-1:0]  rel_cnt_r;
  logic             key_held_r;

  key_code_t        key_code_r;
  logic             key_valid_r;
  logic             overflow_r;

  logic             sample_s;
  logic             match_s;
  logic             confirm_s;
  logic             take_s;
  logic [1:0]       next_row_s;
  key_code_t        pend_code_s;

  sync2 u_sync2 (
    .clk (clk),
    .rst (rst),
    .d   (col_n),
    .q   (col_s)
  );

  // Sample-point and hand-over decode shared by the FSM and the buffer.
  always_comb begin
    sample_s    = (dwell_r == CNT_LAST);
    match_s     = (col_s == lat_col_r);
    next_row_s  = row_idx_r + 2'd1;
    // row_idx_r stays frozen outside SCAN, so it is the latched row here.
    pend_code_s = key_map(row_idx_r, lat_col_idx_r);
    confirm_s   = (state_r == DEBOUNCE) && sample_s && match_s && (match_cnt_r == DB_LAST);
    take_s      = kbus.key_ack && key_valid_r;
  end

  // Scan / debounce / held FSM with dwell counter and row drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= SCAN;
      dwell_r       <= {CNT_W{1'b0}};
      row_idx_r     <= 2'd0;
      row_n         <= 4'b1110;
      lat_col_r     <= 4'hF;
      lat_col_idx_r <= 2'd0;
      match_cnt_r   <= {DB_W{1'b0}};
      rel_cnt_r     <= {DB_W{1'b0}};
      key_held_r    <= 1'b0;
    end else begin
      // Dwell restarts at 0 after every sample point, so a row advance
      // always begins a fresh dwell.
      if (sample_s) begin
        dwell_r <= {CNT_W{1'b0}};
      end else begin
        dwell_r <= dwell_r + CNT_W'(1);
      end

      case (state_r)
        SCAN: begin
          if (sample_s) begin
            if (single_low(col_s)) begin
              lat_col_r     <= col_s;
              lat_col_idx_r <= low_index(col_s);
              match_cnt_r   <= {DB_W{1'b0}};
              state_r       <= DEBOUNCE;
            end else begin
              row_idx_r <= next_row_s;
              row_n     <= ~(4'b0001 << next_row_s);
            end
          end
        end

        DEBOUNCE: begin
          if (sample_s) begin
            if (!match_s) begin
              state_r   <= SCAN;
              row_idx_r <= next_row_s;
              row_n     <= ~(4'b0001 << next_row_s);
            end else if (match_cnt_r == DB_LAST) begin
              state_r    <= HELD;
              key_held_r <= 1'b1;
              rel_cnt_r  <= {DB_W{1'b0}};
            end else begin
              match_cnt_r <= match_cnt_r + DB_W'(1);
            end
          end
        end

        HELD: begin
          if (sample_s) begin
            if (col_s == 4'hF) begin
              if (rel_cnt_r == DB_LAST) begin
                state_r    <= SCAN;
                key_held_r <= 1'b0;
                rel_cnt_r  <= {DB_W{1'b0}};
                row_idx_r  <= next_row_s;
                row_n      <= ~(4'b0001 << next_row_s);
              end else begin
                rel_cnt_r <= rel_cnt_r + DB_W'(1);
              end
            end else begin
              // Any low bit means the key is still down; restart release count.
              rel_cnt_r <= {DB_W{1'b0}};
            end
          end
        end

        default: begin
          state_r    <= SCAN;
          key_held_r <= 1'b0;
          row_idx_r  <= 2'd0;
          row_n      <= 4'b1110;
        end
      endcase
    end
  end

  // One-entry hand-over buffer with sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_code_r  <= KEY_0;
      key_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      if (confirm_s) begin
        if (!key_valid_r || kbus.key_ack) begin
          // An ack in the same cycle frees the slot for the new key.
          key_code_r  <= pend_code_s;
          key_valid_r <= 1'b1;
          if (take_s) begin
            overflow_r <= 1'b0;
          end else begin
            overflow_r <= overflow_r;
          end
        end else begin
          overflow_r <= 1'b1;
        end
      end else if (take_s) begin
        key_valid_r <= 1'b0;
        overflow_r  <= 1'b0;
      end else begin
        key_valid_r <= key_valid_r;
        overflow_r  <= overflow_r;
      end
    end
  end

  assign kbus.key_code  = key_code_r;
  assign kbus.key_valid = key_valid_r;
  assign kbus.overflow  = overflow_r;
  assign kbus.key_held  = key_held_r;

endmodule

// File: tb/tb_keypad_bcd_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_bcd_scanner
// Directed bench for keypad_bcd_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=2).
// A behavioural keypad matrix turns the pressed-key set and the driven row
// into column levels; an override forces raw column patterns for bounce.
// ---------------------------------------------------------------------------
module tb_keypad_bcd_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_n;
  logic [3:0]  col_n;

  logic [15:0] pressed;
  logic        force_en;
  logic [3:0]  force_val;

  int n_checks = 0;
  int n_pass   = 0;

  keypad_bcd_scanner_if kb ();

  keypad_bcd_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .row_n (row_n),
    .col_n (col_n),
    .kbus  (kb)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key on the driven row pulls its column low.
  always_comb begin
    logic [3:0] model;
    model = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4 + c] && !row_n[r]) model[c] = 1'b0;
      end
    end
    col_n = force_en ? force_val : model;
  end

  function automatic int kidx(input int r, input int c);
    return r * 4 + c;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // sel: 0=row_n, 1=key_valid, 2=key_held. Waits at least one cycle.
  task automatic wait_for(input string tag, input int sel, input logic [3:0] val, input int bound);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < bound && !hit; i++) begin
      @(negedge clk);
      case (sel)
        0:       hit = (row_n == val);
        1:       hit = (kb.key_valid == val[0]);
        default: hit = (kb.key_held == val[0]);
      endcase
    end
    check(tag, {31'd0, hit}, 32'd1);
  endtask

  task automatic ack_key();
    kb.key_ack = 1'b1;
    @(negedge clk);
    kb.key_ack = 1'b0;
  endtask

  initial begin
    int         n;
    int         changes;
    logic       seen;
    logic [3:0] prev;
    logic [3:0] r0;

    rst       = 1'b1;
    pressed   = 16'h0000;
    force_en  = 1'b0;
    force_val = 4'hF;
    kb.key_ack = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_row_n",    {28'd0, row_n},       32'hE);
    check("rst_valid",    {31'd0, kb.key_valid}, 32'd0);
    check("rst_overflow", {31'd0, kb.overflow},  32'd0);
    check("rst_held",     {31'd0, kb.key_held},  32'd0);
    check("rst_code",     {28'd0, kb.key_code},  32'd0);

    // Reset asserted while a key is held
    rst = 1'b0;
    pressed[kidx(1, 1)] = 1'b1;
    wait_for("tmo_held_pre_rst", 2, 4'h1, 100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midheld_rst_row_n",    {28'd0, row_n},        32'hE);
    check("midheld_rst_valid",    {31'd0, kb.key_valid}, 32'd0);
    check("midheld_rst_overflow", {31'd0, kb.overflow},  32'd0);
    check("midheld_rst_held",     {31'd0, kb.key_held},  32'd0);

    // Clean press of "5": redetected after reset; latency from row1 drive
    // is one dwell to the detecting sample plus 2*4 debounce cycles.
    wait_for("tmo_row1", 0, 4'b1101, 20);
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(negedge clk);
      if (kb.key_valid) n = i;
    end
    check("press5_latency", n, 32'd12);
    check("press5_code",    {28'd0, kb.key_code}, 32'h5);
    check("press5_held",    {31'd0, kb.key_held}, 32'd1);
    ack_key();
    check("press5_ack_valid", {31'd0, kb.key_valid}, 32'd0);
    repeat (40) @(negedge clk);
    check("press5_single_key", {31'd0, kb.key_valid}, 32'd0);
    check("press5_still_held", {31'd0, kb.key_held},  32'd1);
    pressed = 16'h0000;
    wait_for("tmo_release5", 2, 4'h0, 40);
    check("release5_next_row", {28'd0, row_n}, 32'hB);

    // Bounce: column toggles between samples, never two matches in a row
    force_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      force_val = (i % 2 == 0) ? 4'b1110 : 4'b1111;
      repeat (4) begin
        @(negedge clk);
        seen = seen | kb.key_valid;
      end
    end
    force_en = 1'b0;
    check("bounce_no_key", {31'd0, seen}, 32'd0);
    prev = row_n;
    for (int i = 0; i < 20 && row_n == prev; i++) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      r0 = row_n;
      repeat (4) @(negedge clk);
      check("bounce_row_cycle", {28'd0, row_n}, {28'd0, r0[2:0], r0[3]});
    end

    // Ghost: two columns low in row2
    pressed[kidx(2, 0)] = 1'b1;
    pressed[kidx(2, 1)] = 1'b1;
    seen = 1'b0;
    changes = 0;
    prev = row_n;
    repeat (64) begin
      @(negedge clk);
      if (row_n != prev) changes++;
      prev = row_n;
      seen = seen | kb.key_valid;
    end
    check("ghost_no_key",      {31'd0, seen}, 32'd0);
    check("ghost_row_changes", changes,       32'd16);
    pressed = 16'h0000;

    // Overflow: "#" buffered, "0" confirmed while full
    pressed[kidx(3, 2)] = 1'b1;
    wait_for("tmo_hash_valid", 1, 4'h1, 100);
    check("hash_code", {28'd0, kb.key_code}, 32'hF);
    pressed = 16'h0000;
    wait_for("tmo_hash_release", 2, 4'h0, 60);
    pressed[kidx(3, 1)] = 1'b1;
    wait_for("tmo_zero_held", 2, 4'h1, 100);
    check("ovf_code_kept", {28'd0, kb.key_code},  32'hF);
    check("ovf_valid",     {31'd0, kb.key_valid}, 32'd1);
    check("ovf_flag",      {31'd0, kb.overflow},  32'd1);
    pressed = 16'h0000;
    wait_for("tmo_zero_release", 2, 4'h0, 60);
    ack_key();
    check("ovf_ack_valid", {31'd0, kb.key_valid}, 32'd0);
    check("ovf_ack_flag",  {31'd0, kb.overflow},  32'd0);

    // Simultaneous ack and confirm: "7" buffered, ack on the "D" confirm edge
    pressed[kidx(2, 0)] = 1'b1;
    wait_for("tmo_seven_valid", 1, 4'h1, 100);
    check("seven_code", {28'd0, kb.key_code}, 32'h7);
    pressed = 16'h0000;
    wait_for("tmo_seven_release", 2, 4'h0, 60);
    wait_for("tmo_row0", 0, 4'b1110, 40);
    pressed[kidx(3, 3)] = 1'b1;
    wait_for("tmo_row3", 0, 4'b0111, 40);
    repeat (11) @(negedge clk);
    ack_key();
    check("simul_valid",    {31'd0, kb.key_valid}, 32'd1);
    check("simul_code",     {28'd0, kb.key_code},  32'hD);
    check("simul_overflow", {31'd0, kb.overflow},  32'd0);
    check("simul_held",     {31'd0, kb.key_held},  32'd1);
    pressed = 16'h0000;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
